// File: rtl/minhash_topk_sorter.sv
// minhash_topk_sorter
// Streaming bottom-K MinHash sorter between the hasher and the extender.
// Collects {signature, index} pairs for one fragment, keeps the K smallest
// signatures in ascending order, then drains them in rank order with a
// position tag under a valid/ready handshake.
module minhash_topk_sorter #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 4,
  parameter int K     = 2,
  parameter int DEDUP = 1,
  parameter int POS_W = $clog2(K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_signature,
  input  logic [IDX_W-1:0] in_index,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_signature,
  output logic [IDX_W-1:0] out_index,
  output logic [POS_W-1:0] out_position,
  output logic             out_last,
  output logic [POS_W:0]   count
);

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_DRAIN   = 1'b1;

  localparam logic [POS_W:0]   CNT_FULL = (POS_W+1)'(K);
  localparam logic [POS_W:0]   CNT_ONE  = (POS_W+1)'(1);
  localparam logic [POS_W-1:0] PTR_ONE  = POS_W'(1);

  logic             state;
  logic [POS_W:0]   count_q;
  logic [POS_W-1:0] rd_ptr;

  // Slot array, ascending by signature; valid bits are contiguous from 0.
  logic [K-1:0]     ent_valid;
  logic [SIG_W-1:0] ent_sig [K];
  logic [IDX_W-1:0] ent_idx [K];

  // Per-slot compare results and the post-insert image of the array.
  logic [K-1:0]     le;
  logic [K-1:0]     eq;
  logic [K-1:0]     nxt_valid;
  logic [SIG_W-1:0] nxt_sig [K];
  logic [IDX_W-1:0] nxt_idx [K];

  logic accept;
  logic dup;
  logic discard;
  logic insert;
  logic drain_done;

  // le is a thermometer over the sorted slots: le[i] means slot i stays
  // below the insertion point. Each slot then keeps its entry, takes the
  // new pair, or takes its lower neighbour (shift up by one).
  for (genvar g = 0; g < K; g++) begin : g_slot
    assign le[g] = ent_valid[g] && (ent_sig[g] <= in_signature);
    assign eq[g] = ent_valid[g] && (ent_sig[g] == in_signature);

    if (g == 0) begin : g_head
      assign nxt_valid[g] = 1'b1;
      assign nxt_sig[g]   = le[g] ? ent_sig[g] : in_signature;
      assign nxt_idx[g]   = le[g] ? ent_idx[g] : in_index;
    end else begin : g_body
      assign nxt_valid[g] = le[g]   ? ent_valid[g]   :
                            le[g-1] ? 1'b1           : ent_valid[g-1];
      assign nxt_sig[g]   = le[g]   ? ent_sig[g]     :
                            le[g-1] ? in_signature   : ent_sig[g-1];
      assign nxt_idx[g]   = le[g]   ? ent_idx[g]     :
                            le[g-1] ? in_index       : ent_idx[g-1];
    end
  end

  assign accept = in_valid && in_ready;
  assign dup    = (DEDUP != 0) && (|eq);
  // le[K-1] is set only when the array is full and the new signature is not
  // below the largest stored one, i.e. the insertion point falls off the end.
  assign discard = dup || le[K-1];
  assign insert  = accept && !discard;

  assign drain_done = (state == ST_DRAIN) && out_ready && out_last;

  // Slot storage: parallel insert while collecting, bulk invalidate after
  // the final drain handshake.
  // NOTE: slot payloads are reset along with the valid bits so that the
  // output bus reads zero out of reset; this is K small registers, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      for (int i = 0; i < K; i++) begin
        ent_sig[i] <= '0;
        ent_idx[i] <= '0;
      end
    end else if (drain_done) begin
      ent_valid <= '0;
    end else if (insert) begin
      ent_valid <= nxt_valid;
      for (int i = 0; i < K; i++) begin
        ent_sig[i] <= nxt_sig[i];
        ent_idx[i] <= nxt_idx[i];
      end
    end
  end

  // Control: COLLECT/DRAIN sequencing, stored-entry count, drain read pointer.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_COLLECT;
      count_q <= '0;
      rd_ptr  <= '0;
    end else if (state == ST_COLLECT) begin
      if (insert && (count_q != CNT_FULL)) begin
        count_q <= count_q + CNT_ONE;
      end
      if (accept && in_last) begin
        state <= ST_DRAIN;
      end
    end else if (out_ready) begin
      if (out_last) begin
        state   <= ST_COLLECT;
        count_q <= '0;
        rd_ptr  <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign in_ready      = (state == ST_COLLECT);
  assign out_valid     = (state == ST_DRAIN);
  assign out_signature = ent_sig[rd_ptr];
  assign out_index     = ent_idx[rd_ptr];
  assign out_position  = rd_ptr;
  assign out_last      = out_valid && ({1'b0, rd_ptr} == (count_q - CNT_ONE));
  assign count         = count_q;

endmodule

// File: doc/minhash_topk_sorter.md
Name: minhash_topk_sorter

Overview:
- Streaming bottom-K MinHash sorter. Sits between the hasher and the extender.
- Accepts one {signature, index} pair per cycle for a fragment and keeps the K smallest signatures in ascending order.
- At fragment end, drains them in rank order with a position tag.
- Generalises the fixed two-index sorter to parametric K, signature width and index width, and adds an optional duplicate-signature filter and a back-pressured drain.

Parameters:
- SIG_W, 32, signature width in bits (hasher output).
- IDX_W, 4, k-mer index width in bits.
- K, 2, number of minimum signatures retained per fragment; legal K >= 2.
- DEDUP, 1, 1 = drop an input whose signature equals a stored one; 0 = keep duplicates.
- POS_W, $clog2(K), width of the rank/position output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  sorter can accept input
- in_signature  in  SIG_W  hashed k-mer signature
- in_index  in  IDX_W  k-mer index within fragment
- in_last  in  1  final k-mer of current fragment (qualified by in_valid)
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts output
- out_signature  out  SIG_W  signature of current rank
- out_index  out  IDX_W  index of current rank
- out_position  out  POS_W  rank, 0 = smallest
- out_last  out  1  final entry of the fragment
- count  out  POS_W+1  number of entries currently stored (0..K)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state COLLECT, all entry valid bits 0, count 0, rd_ptr 0, in_ready 1, out_valid 0, out_last 0, out_position 0, out_signature 0, out_index 0.
- Storage: K entries {valid, signature, index}, kept ascending by unsigned signature. Valid entries are always contiguous from position 0.
- FSM has two states, COLLECT and DRAIN.
- COLLECT:
  - in_ready = 1, out_valid = 0.
  - Accept when in_valid && in_ready. Insert in the same cycle using parallel compare-and-shift.
  - Insertion point p = number of valid entries with signature <= in_signature. Entries at p..K-2 shift up one position; entry K-1 falls off when full.
  - Full and in_signature >= entry[K-1].signature: input discarded, array unchanged.
  - Equal signature, DEDUP=1: input discarded, and the first-stored index is kept.
  - Equal signature, DEDUP=0: new entry goes after all equal entries (stable order).
  - count updates one cycle after acceptance and saturates at K.
  - Accepted beat with in_last = 1: the insert/discard rule applies to that beat, then the next state is DRAIN.
- DRAIN:
  - in_ready = 0, out_valid = 1.
  - Outputs show entry[rd_ptr]; out_position = rd_ptr; out_last = (rd_ptr == count-1).
  - rd_ptr advances on out_valid && out_ready.
  - On the handshake with out_last = 1: clear all valid bits, set count = 0 and rd_ptr = 0, and return to COLLECT. in_ready is 1 in the following cycle.
  - Outputs are stable while out_valid && !out_ready.
- Latency: in_last accepted in cycle t gives out_valid = 1 in cycle t+1. A drain of n entries with out_ready held high takes n cycles.
- Empty fragment: the first accepted beat is always stored, so count >= 1 at DRAIN entry. in_last therefore always produces at least one output.
- Reset mid-operation: an asynchronous clear of everything to the reset values. A partial fragment or drain is abandoned with no output.
- in_signature, in_index and in_last are ignored when in_valid = 0 or in_ready = 0.
- Comparisons are unsigned, full SIG_W width. Signature all-ones is a legal value and is not a sentinel; the valid bits carry occupancy.

Test Plan:
- K=4, DEDUP=1: stream sigs 50,20,80,10,60 (idx 0..4), last on idx 4, out_ready=1.
  - Required outputs (sig/idx/pos): 10/3/0, 20/1/1, 50/0/2, 60/4/3.
  - out_last only on pos 3. out_valid starts the cycle after in_last.
- K=4, DEDUP=1: sigs 30,30,5 (idx 0,1,2), last on idx 2 -> outputs 5/2/0, 30/0/1, count=2.
- K=4, DEDUP=0: same input -> outputs 5/2, 30/0, 30/1.
- K=2: sigs 7,3,9,3,1, last on idx 4 -> 1/4, 3/1.
  - sig 9 is discarded while full.
  - The second 3 is dropped with DEDUP=1.
- Back-pressure during drain:
  - Toggle out_ready 1,0,0,1 during drain -> outputs hold while out_ready=0, and no entry is skipped or repeated.
  - in_ready=0 throughout the drain.
  - in_ready=1 in the cycle after the out_last handshake.
- rst asserted asynchronously mid-COLLECT with count=3 and again mid-DRAIN at rd_ptr=1 -> immediate out_valid=0, count=0.
  - The next fragment 4,2 (last) outputs only 2/1, 4/0.
